// File: rtl/run_host_pkg.sv
// run_host_pkg: shared definitions for the host-side run sequencer and the
// core top level (memory map of the operand/result convention, FSM states).
// No ports; imported with `import run_host_pkg::*;`.
package run_host_pkg;

    // Data-memory operand/result convention shared with the core top level.
    localparam int unsigned EXP_ADDR  = 4;
    localparam int unsigned CNT_ADDR  = 5;
    localparam int unsigned RES_BASE  = 0;
    localparam int unsigned RES_WORDS = 4;

    // Width of the shared RUN/READ counter and of the reported cycle count.
    localparam int unsigned CNT_W = 12;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_EXP = 3'd1,
        S_LOAD_CNT = 3'd2,
        S_START    = 3'd3,
        S_RUN      = 3'd4,
        S_READ     = 3'd5,
        S_REPORT   = 3'd6
    } state_t;

endpackage

// File: rtl/run_host.sv
// run_host: host-side sequencer for the 9-bit core. On `go` it writes the
// exponent/counter operands to data memory, pulses `cpu_start`, waits for
// `cpu_done` under a cycle budget, then reads four result bytes back.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   go, exp_in, cnt_in        run request and operands (latched at go)
//   mem_own                   host owns the data-memory port
//   mem_wr_en/mem_rd_en       data-memory strobes
//   mem_addr/mem_wdata        data-memory address / write data
//   mem_rdata                 data-memory read data (combinational)
//   cpu_start, cpu_done       core handshake (launch on start fall, done pulse)
//   busy                      high outside IDLE
//   result_valid              one-cycle pulse in REPORT
//   result, cycles, timeout   run outcome, held until the next accepted go
module run_host
    import run_host_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned TIMEOUT   = 2000,
    parameter int unsigned START_LEN = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [7:0]       exp_in,
    input  logic [7:0]       cnt_in,
    output logic             mem_own,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic             cpu_start,
    input  logic             cpu_done,
    output logic             busy,
    output logic             result_valid,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] cycles,
    output logic             timeout
);

    if (TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_timeout
        $error("run_host: TIMEOUT must be in 1..4095");
    end
    if (START_LEN < 1) begin : g_bad_start_len
        $error("run_host: START_LEN must be at least 1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(RES_WORDS - 1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [7:0]       exp_op_q,  exp_op_d;
    logic [7:0]       cnt_op_q,  cnt_op_d;
    logic [31:0]      result_q,  result_d;
    logic [CNT_W-1:0] cycles_q,  cycles_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            exp_op_q  <= '0;
            cnt_op_q  <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_op_q  <= exp_op_d;
            cnt_op_q  <= cnt_op_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_op_d  = exp_op_q;
        cnt_op_d  = cnt_op_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;

        mem_own      = 1'b0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cpu_start    = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    exp_op_d  = exp_in;
                    cnt_op_d  = cnt_in;
                    result_d  = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = S_LOAD_EXP;
                end
            end
            S_LOAD_EXP: begin
                mem_own   = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = AW'(EXP_ADDR);
                mem_wdata = exp_op_q;
                state_d   = S_LOAD_CNT;
            end
            S_LOAD_CNT: begin
                mem_own   = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = AW'(CNT_ADDR);
                mem_wdata = cnt_op_q;
                cnt_d     = '0;
                state_d   = S_START;
            end
            S_START: begin
                // The same counter times the start pulse, then restarts for RUN.
                cpu_start = 1'b1;
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // done wins over the budget when both land in the same cycle.
                if (cpu_done) begin
                    cycles_d = cnt_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = S_READ;
                end else if (cnt_q == RUN_LAST) begin
                    timeout_d = 1'b1;
                    cycles_d  = TIMEOUT_C;
                    cnt_d     = '0;
                    state_d   = S_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                mem_own   = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = AW'(RES_BASE) + AW'(cnt_q);
                unique case (cnt_q[1:0])
                    2'd0:    result_d[7:0]   = mem_rdata;
                    2'd1:    result_d[15:8]  = mem_rdata;
                    2'd2:    result_d[23:16] = mem_rdata;
                    default: result_d[31:24] = mem_rdata;
                endcase
                if (cnt_q == READ_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign result  = result_q;
    assign cycles  = cycles_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_run_host.sv
module tb_run_host;

    localparam int TO = 16;
    localparam int SL = 2;
    localparam int LIM = 2 + SL + TO + 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [7:0]  exp_in, cnt_in;
    logic        mem_own, mem_wr_en, mem_rd_en;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        cpu_start, cpu_done, busy, result_valid, timeout;
    logic [31:0] result;
    logic [11:0] cycles;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_host #(.AW(8), .TIMEOUT(TO), .START_LEN(SL)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .exp_in(exp_in), .cnt_in(cnt_in),
        .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy),
        .result_valid(result_valid), .result(result), .cycles(cycles),
        .timeout(timeout)
    );

    // Data-memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One complete transaction. r = RUN cycle in which done is raised (0 = never).
    // Expectations come from the sequence rules: writes in cycles 0/1, start
    // for SL cycles from cycle 2, report in cycle 2+SL+R+4 with R the effective
    // run length (capped at the budget).
    task automatic do_run(input logic [7:0] e, input logic [7:0] c, input int r,
                          input bit stray, input logic [31:0] bytes);
        int wk[$];
        int wa[$];
        int wd[$];
        int start_cnt = 0, start_first = -1, rv_cnt = 0, rv_k = -1;
        int reff;
        bit exp_to;
        logic [31:0] rv_res = '0;
        logic [11:0] rv_cyc = '0;
        logic        rv_to = 1'b0;

        mem[0] = bytes[7:0];
        mem[1] = bytes[15:8];
        mem[2] = bytes[23:16];
        mem[3] = bytes[31:24];
        exp_to = (r == 0) || (r > TO);
        reff   = exp_to ? TO : r;

        exp_in = e;
        cnt_in = c;
        go     = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int k = 0; k < LIM; k++) begin
            cpu_done = ((r != 0) && (k == 2 + SL + r - 1)) || (stray && k == 1);
            go       = stray && (k == 2 + SL + 1);
            @(negedge clk);
            if (mem_wr_en) begin
                wk.push_back(k);
                wa.push_back(int'(mem_addr));
                wd.push_back(int'(mem_wdata));
            end
            if (cpu_start) begin
                start_cnt++;
                if (start_first < 0) start_first = k;
            end
            if (result_valid) begin
                rv_cnt++;
                rv_k   = k;
                rv_res = result;
                rv_cyc = cycles;
                rv_to  = timeout;
            end
            @(posedge clk);
            #1;
        end
        cpu_done = 1'b0;
        go       = 1'b0;

        chk("n_writes", 64'(wk.size()), 64'd2);
        if (wk.size() == 2) begin
            chk("w0_cycle", 64'(wk[0]), 64'd0);
            chk("w0_addr",  64'(wa[0]), 64'd4);
            chk("w0_data",  64'(wd[0]), 64'(e));
            chk("w1_cycle", 64'(wk[1]), 64'd1);
            chk("w1_addr",  64'(wa[1]), 64'd5);
            chk("w1_data",  64'(wd[1]), 64'(c));
        end
        chk("mem_exp", 64'(mem[4]), 64'(e));
        chk("mem_cnt", 64'(mem[5]), 64'(c));
        chk("start_len",   64'(start_cnt),   64'(SL));
        chk("start_first", 64'(start_first), 64'd2);
        chk("rv_pulses",   64'(rv_cnt),      64'd1);
        chk("rv_cycle",    64'(rv_k),        64'(2 + SL + reff + 4));
        chk("rv_result",   64'(rv_res),      64'(bytes));
        chk("rv_cycles",   64'(rv_cyc),      64'(reff));
        chk("rv_timeout",  64'(rv_to),       64'(exp_to));
        chk("held_result", 64'(result),      64'(bytes));
        chk("held_cycles", 64'(cycles),      64'(reff));
        chk("held_tmo",    64'(timeout),     64'(exp_to));
        chk("idle_busy",   64'(busy),        64'd0);
    endtask

    initial begin
        logic [7:0] e, c;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset_n  = 1'b0;
        go       = 1'b0;
        exp_in   = '0;
        cnt_in   = '0;
        cpu_done = 1'b0;
        #1;
        chk("rst_ctl", 64'({mem_own, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
                            cpu_start, busy, result_valid}), 64'd0);
        chk("rst_res", 64'({result, cycles, timeout}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run.
        do_run(8'h15, 8'h0F, 10, 1'b0, 32'h44332211);
        // Budget expires without done.
        do_run(8'hA5, 8'h3C, 0, 1'b0, 32'hDEADBEEF);
        // done in the very cycle the budget expires.
        do_run(8'h01, 8'h02, TO, 1'b0, 32'h0BADF00D);
        // done in the first RUN cycle.
        do_run(8'h7E, 8'h81, 1, 1'b0, 32'h12345678);
        // Stray go in RUN and stray done in LOAD_CNT.
        do_run(8'h5A, 8'hC3, 7, 1'b1, 32'hCAFE0042);

        // Asynchronous reset while cpu_start is high.
        exp_in = 8'hEE;
        cnt_in = 8'hDD;
        go     = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_start", 64'(cpu_start), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({mem_own, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
                                cpu_start, busy, result_valid}), 64'd0);
        chk("mid_rst_res", 64'({result, cycles, timeout}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_run(8'h33, 8'h44, 5, 1'b0, 32'h89ABCDEF);

        // Randomized runs, some past the budget.
        for (int n = 0; n < 8; n++) begin
            e = 8'($urandom);
            c = 8'($urandom);
            do_run(e, c, int'($urandom_range(0, TO + 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
